// File: rtl/nibble_assembler_if.sv
// rtl/nibble_assembler_if.sv - serial-in / word-out handshake bundle for nibble_assembler
interface nibble_assembler_if #(
    parameter int WIDTH = 4
);
    logic             s_valid;
    logic             s_data;
    logic             s_sync;
    logic             s_ready;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_load;
    logic             err_frame;
    logic [7:0]       err_cnt;

    modport slave (
        input  s_valid, s_data, s_sync, m_ready,
        output s_ready, m_valid, m_data, m_load, err_frame, err_cnt
    );

    modport master (
        output s_valid, s_data, s_sync, m_ready,
        input  s_ready, m_valid, m_data, m_load, err_frame, err_cnt
    );
endinterface

// File: rtl/nibble_assembler.sv
// rtl/nibble_assembler.sv - framed serial-to-parallel word assembler with one-entry output buffer
module nibble_assembler #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    nibble_assembler_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {SEARCH, COLLECT} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             m_valid_q, m_valid_d;
    logic [WIDTH-1:0] m_data_q, m_data_d;
    logic             err_frame_q, err_frame_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    logic             s_ready;
    logic             accept;
    logic             m_load;
    logic [WIDTH-1:0] placed;
    logic [WIDTH-1:0] first;
    logic             word_done;

    always_comb begin
        // Only the bit that would complete a word must wait for a full buffer to drain.
        s_ready = !(state_q == COLLECT && cnt_q == LAST && m_valid_q && !bus.m_ready);
        accept  = bus.s_valid & s_ready;
        m_load  = m_valid_q & bus.m_ready;
        first   = {{(WIDTH-1){1'b0}}, bus.s_data};

        if (MSB_FIRST) begin
            placed = {shift_q[WIDTH-2:0], bus.s_data};
        end else begin
            placed = shift_q;
            placed[cnt_q] = bus.s_data;
        end

        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        err_frame_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        word_done   = 1'b0;

        if (accept) begin
            if (state_q == SEARCH) begin
                if (bus.s_sync) begin
                    shift_d = first;
                    cnt_d   = CW'(1);
                    state_d = COLLECT;
                end
            end else if (bus.s_sync && cnt_q != '0) begin
                // Misaligned sync: drop the partial word and restart on this bit.
                shift_d     = first;
                cnt_d       = CW'(1);
                err_frame_d = 1'b1;
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
            end else if (cnt_q == LAST) begin
                shift_d   = placed;
                cnt_d     = '0;
                word_done = 1'b1;
            end else begin
                shift_d = placed;
                cnt_d   = cnt_q + CW'(1);
            end
        end

        if (word_done) begin
            m_valid_d = 1'b1;
            m_data_d  = placed;
        end else if (m_load) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SEARCH;
            cnt_q       <= '0;
            shift_q     <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            err_frame_q <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            err_frame_q <= err_frame_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.s_ready   = s_ready;
    assign bus.m_valid   = m_valid_q;
    assign bus.m_data    = m_data_q;
    assign bus.m_load    = m_load;
    assign bus.err_frame = err_frame_q;
    assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_nibble_assembler.sv
// tb/tb_nibble_assembler.sv - scoreboard bench for nibble_assembler, MSB-first and LSB-first instances
module tb_nibble_assembler;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    nibble_assembler_if #(.WIDTH(W)) bus0 ();
    nibble_assembler_if #(.WIDTH(W)) bus1 ();

    nibble_assembler #(.WIDTH(W), .MSB_FIRST(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    nibble_assembler #(.WIDTH(W), .MSB_FIRST(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    assign bus1.s_valid = bus0.s_valid;
    assign bus1.s_data  = bus0.s_data;
    assign bus1.s_sync  = bus0.s_sync;
    assign bus1.m_ready = bus0.m_ready;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: bits of the word in progress, buffer occupancy, error tally.
    bit         in_word  = 1'b0;
    bit         cur[$];
    bit         out_full = 1'b0;
    int         err_count = 0;
    bit         exp_err  = 1'b0;
    logic [W-1:0] exp0[$];
    logic [W-1:0] exp1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pack(input bit msb_first);
        int v = 0;
        for (int k = 0; k < W; k++) begin
            if (cur[k]) v += msb_first ? (1 << (W - 1 - k)) : (1 << k);
        end
        return W'(v);
    endfunction

    function automatic int sat_cnt();
        return (err_count > 255) ? 255 : err_count;
    endfunction

    task automatic model_clear();
        in_word = 1'b0;
        cur.delete();
        out_full = 1'b0;
        err_count = 0;
        exp_err = 1'b0;
        exp0.delete();
        exp1.delete();
    endtask

    task automatic drive(input bit v, input bit d, input bit s, input bit mr, output bit acc);
        bit pred_ready;
        bit done;
        bit err;
        @(posedge clk);
        #1;
        check("m_valid", bus0.m_valid, out_full);
        check("m_valid_lsb", bus1.m_valid, out_full);
        check("err_frame", bus0.err_frame, exp_err);
        check("err_cnt", bus0.err_cnt, sat_cnt());
        bus0.s_valid = v;
        bus0.s_data  = d;
        bus0.s_sync  = s;
        bus0.m_ready = mr;
        pred_ready = !(in_word && cur.size() == W - 1 && out_full && !mr);
        #1;
        check("s_ready", bus0.s_ready, pred_ready);
        check("m_load", bus0.m_load, out_full && mr);
        acc  = v && pred_ready;
        done = 1'b0;
        err  = 1'b0;
        if (acc) begin
            if (s) begin
                if (in_word && cur.size() != 0) err = 1'b1;
                cur.delete();
                cur.push_back(d);
                in_word = 1'b1;
            end else if (in_word) begin
                cur.push_back(d);
            end
            if (in_word && cur.size() == W) begin
                exp0.push_back(pack(1'b1));
                exp1.push_back(pack(1'b0));
                cur.delete();
                done = 1'b1;
            end
        end
        if (out_full && mr) out_full = 1'b0;
        if (done) out_full = 1'b1;
        if (err) err_count++;
        exp_err = err;
    endtask

    task automatic send_bit(input bit d, input bit s, input bit mr);
        bit acc;
        int tries = 0;
        do begin
            drive(1'b1, d, s, mr, acc);
            tries++;
        end while (!acc && tries < 16);
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit sync_first, input bit mr);
        logic [W-1:0] t;
        t = w;
        for (int k = 0; k < W; k++) send_bit(t[W-1-k], sync_first && k == 0, mr);
    endtask

    task automatic idle(input int n, input bit mr);
        bit acc;
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, mr, acc);
    endtask

    task automatic reset_mid();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_m_valid", bus0.m_valid, 0);
        check("rst_m_data", bus0.m_data, 0);
        check("rst_m_data_lsb", bus1.m_data, 0);
        check("rst_err_frame", bus0.err_frame, 0);
        check("rst_err_cnt", bus0.err_cnt, 0);
        bus0.s_valid = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus0.m_valid === 1'b1 && bus0.m_ready === 1'b1) begin
            if (exp0.size() == 0) check("m_data_unexpected", {28'd0, bus0.m_data}, 32'hFFFF_FFFF);
            else check("m_data_msb", bus0.m_data, exp0.pop_front());
            if (exp1.size() == 0) check("m_data_lsb_unexpected", {28'd0, bus1.m_data}, 32'hFFFF_FFFF);
            else check("m_data_lsb", bus1.m_data, exp1.pop_front());
        end
    end

    initial begin
        bit acc;
        rst_n = 1'b0;
        bus0.s_valid = 1'b0;
        bus0.s_data  = 1'b0;
        bus0.s_sync  = 1'b0;
        bus0.m_ready = 1'b1;
        #2;
        check("init_m_valid", bus0.m_valid, 0);
        check("init_m_data", bus0.m_data, 0);
        check("init_err_cnt", bus0.err_cnt, 0);
        check("init_s_ready", bus0.s_ready, 1);
        #10;
        rst_n = 1'b1;

        // Single synced word, then unsynced noise ignored
        send_word(4'b1011, 1'b1, 1'b1);
        idle(3, 1'b1);
        reset_mid();
        for (int k = 0; k < 6; k++) send_bit(1'($urandom), 1'b0, 1'b1);
        send_word(4'b0110, 1'b1, 1'b1);
        idle(2, 1'b1);

        // Backpressure: only the completing bit of the second word stalls
        send_word(4'b1011, 1'b1, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, acc);
        drive(1'b1, 1'b1, 1'b0, 1'b0, acc);
        send_bit(1'b1, 1'b0, 1'b1);
        idle(3, 1'b1);

        // Misaligned sync, recovery word, then saturate the error counter
        send_bit(1'b1, 1'b0, 1'b1);
        send_bit(1'b0, 1'b0, 1'b1);
        send_bit(1'b1, 1'b1, 1'b1);
        send_bit(1'b1, 1'b0, 1'b1);
        send_bit(1'b0, 1'b0, 1'b1);
        send_bit(1'b0, 1'b0, 1'b1);
        idle(2, 1'b1);
        for (int k = 0; k < 262; k++) send_bit(1'($urandom), 1'b1, 1'b1);
        idle(2, 1'b1);
        check("err_saturated", bus0.err_cnt, 255);

        // Back-to-back words with m_ready held high
        reset_mid();
        send_word(4'b1111, 1'b1, 1'b1);
        send_word(4'b0001, 1'b0, 1'b1);
        idle(2, 1'b1);

        // Async reset mid-word with a full buffer, then LSB-first placement check
        send_word(4'b1010, 1'b1, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        reset_mid();
        for (int k = 0; k < 5; k++) send_bit(1'($urandom), 1'b0, 1'b1);
        send_word(4'b1000, 1'b1, 1'b1);
        idle(2, 1'b1);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            drive(($urandom % 4) != 0, 1'($urandom), ($urandom % 8) == 0, ($urandom % 3) != 0, acc);
        end
        idle(4, 1'b1);
        check("scoreboard_drained", exp0.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
